// File: rtl/note_spawn_if.sv
// Beatmap ROM read port and renderer spawn handshake between the scheduler and
// the surrounding datapath.
interface note_spawn_if #(
  parameter int ADDR_W    = 10,
  parameter int TIME_W    = 16,
  parameter int NUM_LANES = 4
);
  logic [ADDR_W-1:0]           rom_addr;
  logic [TIME_W+NUM_LANES-1:0] rom_data;
  logic                        spawn_valid;
  logic                        spawn_ready;
  logic [NUM_LANES-1:0]        spawn_lane_mask;
  logic [TIME_W-1:0]           spawn_hit_time;

  modport master (
    output rom_addr, spawn_valid, spawn_lane_mask, spawn_hit_time,
    input  rom_data, spawn_ready
  );
  modport slave (
    input  rom_addr, spawn_valid, spawn_lane_mask, spawn_hit_time,
    output rom_data, spawn_ready
  );
endinterface

// File: rtl/note_spawn_scheduler.sv
// Song-time keeper and beatmap walker: releases each chart entry to the arrow
// renderer LEAD_TICKS before its hit time, freezing on pause and rewinding on restart.
module note_spawn_scheduler #(
  parameter int ADDR_W     = 10,
  parameter int TIME_W     = 16,
  parameter int NUM_LANES  = 4,
  parameter int TICK_DIV   = 500000,
  parameter int LEAD_TICKS = 150
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              game_active,
  input  logic              paused,
  input  logic              restart,
  note_spawn_if.master      bus,
  output logic [TIME_W-1:0] song_time,
  output logic              tick,
  output logic [ADDR_W:0]   notes_spawned,
  output logic              chart_done
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] OFFER = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]           state;
  logic [ADDR_W-1:0]    index;
  logic [DIV_W-1:0]     div;
  logic [TIME_W-1:0]    entry_hit;
  logic [NUM_LANES-1:0] entry_mask;
  logic                 run;
  logic                 div_wrap;
  logic                 due;
  logic                 in_offer;

  assign run      = game_active && !paused;
  assign div_wrap = (div == DIV_W'(TICK_DIV - 1));
  assign in_offer = (state == OFFER);
  // One extra bit so song_time + LEAD_TICKS near the top of the range never wraps.
  assign due = {1'b0, entry_hit} <= ({1'b0, song_time} + (TIME_W+1)'(LEAD_TICKS));

  assign bus.rom_addr        = index;
  assign bus.spawn_valid     = run && in_offer;
  assign bus.spawn_lane_mask = in_offer ? entry_mask : '0;
  assign bus.spawn_hit_time  = in_offer ? entry_hit  : '0;
  assign chart_done          = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div       <= '0;
      song_time <= '0;
      tick      <= 1'b0;
    end else if (restart) begin
      div       <= '0;
      song_time <= '0;
      tick      <= 1'b0;
    end else begin
      tick <= run && div_wrap;
      if (run) begin
        div <= div_wrap ? '0 : div + DIV_W'(1);
        if (div_wrap && song_time != '1)
          song_time <= song_time + TIME_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      index         <= '0;
      entry_hit     <= '0;
      entry_mask    <= '0;
      notes_spawned <= '0;
    end else if (restart) begin
      state         <= IDLE;
      index         <= '0;
      entry_hit     <= '0;
      entry_mask    <= '0;
      notes_spawned <= '0;
    end else if (run) begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: state <= LATCH;
        LATCH: begin
          {entry_hit, entry_mask} <= bus.rom_data;
          state                   <= CHECK;
        end
        CHECK: begin
          if (entry_mask == '0)
            state <= DONE;
          else if (due)
            state <= OFFER;
        end
        OFFER: begin
          if (bus.spawn_ready) begin
            notes_spawned <= notes_spawned + (ADDR_W+1)'(1);
            // Last ROM slot ends the chart rather than wrapping back to entry 0.
            if (index == '1) begin
              state <= DONE;
            end else begin
              index <= index + ADDR_W'(1);
              state <= FETCH;
            end
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
